perceptron_weight_loader: RTL and testbench

AXI4-Lite initiator that drains a stream of weight words and writes them into the perceptron's AXI4-Lite weight register file at consecutive word addresses. Sits between the weight source (DMA/ROM streamer) and the perceptron's `s_axi_*` responder port. Replaces bench-driven weight loading in system builds; one `load_start` pulse loads all `N_WEIGHTS` weights, then `load_done` pulses.

---
 rtl/perceptron_pkg.sv | 15 +
 rtl/perceptron_weight_loader.sv | 146 ++++++++++++++
 tb/tb_perceptron_weight_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared constants and loader state encoding for the perceptron block
package perceptron_pkg;

  localparam int          N_WEIGHTS_DEF = 784;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_RESP,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/perceptron_weight_loader.sv
// rtl/perceptron_weight_loader.sv - drains a weight stream into the perceptron register file
// over AXI4-Lite, one outstanding write at a time, consecutive word addresses.
module perceptron_weight_loader
  import perceptron_pkg::*;
#(
  parameter int                N_WEIGHTS = N_WEIGHTS_DEF,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              load_start,
  input  logic [31:0]       w_tdata,
  input  logic              w_tvalid,
  output logic              w_tready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              load_busy,
  output logic              load_done,
  output logic [15:0]       err_count
);

  localparam int IDX_W = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WEIGHTS - 1);

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              aw_hs, w_hs;

  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q && m_axi_wready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          err_d   = '0;
        end
      end
      ST_FETCH: begin
        if (w_tvalid) begin
          wdata_d   = w_tdata;
          awaddr_d  = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // AW and W complete independently; the done flags remember the earlier one.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign w_tready      = (state_q == ST_FETCH);
  assign m_axi_bready  = (state_q == ST_RESP);
  assign load_done     = (state_q == ST_DONE);
  assign load_busy     = (state_q != ST_IDLE);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = 4'b1111;
  assign err_count     = err_q;

endmodule

// File: tb/tb_perceptron_weight_loader.sv
// tb/tb_perceptron_weight_loader.sv - randomized bench for the weight loader with an
// AXI4-Lite responder memory and a weight stream source.
module tb_perceptron_weight_loader;

  localparam int N      = 784;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start;
  logic [31:0]       w_tdata;
  logic              w_tvalid;
  logic              w_tready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic              load_busy, load_done;
  logic [15:0]       err_count;

  always #5 clk = ~clk;

  perceptron_weight_loader #(.N_WEIGHTS(N), .ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .load_start(load_start),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .load_busy(load_busy),
    .load_done(load_done), .err_count(err_count)
  );

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Configuration written only by the main sequence.
  int          load_id  = 0;
  int          src_mode = 0;   // 0 always valid, 1 toggling, 2 random
  int          rsp_mode = 0;   // 0 zero-wait, 1 AW 3 ahead of W, 2 W 3 ahead of AW, 3 random
  bit          err_en   = 1'b0;
  logic [31:0] src_w [N];

  // Observations written only by the bus agent.
  int          seen_id = -1;
  logic [31:0] mem [N];
  int          wcnt [N];
  int          src_ptr, bad_addr, dup_aw, dup_w, unstable, tready_viol, done_cnt;
  bit          aw_got, w_got, aw_pend, w_pend;
  logic [ADDR_W-1:0] got_addr, pend_addr;
  logic [31:0] got_data, pend_data;
  int          cyc, b_wait, aw_dly, w_dly, b_dly;

  // Stream source and AXI4-Lite responder; handshakes are predicted at the negedge for
  // the following posedge, since nothing they depend on changes in between.
  initial begin
    w_tvalid = 1'b0; w_tdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; cyc = 0; b_wait = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; got_addr = '0; got_data = '0;
    pend_addr = '0; pend_data = '0;
    forever begin
      @(negedge clk);
      if (seen_id != load_id) begin
        seen_id = load_id;
        for (int i = 0; i < N; i++) begin mem[i] = '0; wcnt[i] = 0; end
        src_ptr = 0; bad_addr = 0; dup_aw = 0; dup_w = 0; unstable = 0;
        tready_viol = 0; done_cnt = 0;
      end
      if (load_done) done_cnt++;
      if (!rst_n) begin
        w_tvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; cyc = 0; b_wait = 0;
      end else begin
        w_tvalid = (src_ptr < N) &&
                   (src_mode == 0 || (src_mode == 1 && cycle[0]) ||
                    (src_mode == 2 && $urandom_range(0, 1) == 1));
        w_tdata  = (src_ptr < N) ? src_w[src_ptr] : 32'h0;

        if (aw_got && w_got) begin
          if (b_wait >= b_dly) begin
            bvalid = 1'b1;
            bresp  = (err_en && (got_addr == 12'h010 || got_addr == 12'h020)) ? 2'b10 : 2'b00;
          end else begin
            bvalid = 1'b0;
            b_wait++;
          end
        end else begin
          bvalid = 1'b0;
        end

        if ((awvalid || wvalid) && !(aw_got && w_got)) begin
          if (cyc == 0) begin
            case (rsp_mode)
              1: begin aw_dly = 0; w_dly = 3; b_dly = 0; end
              2: begin aw_dly = 3; w_dly = 0; b_dly = 0; end
              3: begin aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
                       b_dly = $urandom_range(0, 3); end
              default: begin aw_dly = 0; w_dly = 0; b_dly = 0; end
            endcase
          end
          awready = !aw_got && (cyc >= aw_dly);
          wready  = !w_got && (cyc >= w_dly);
          cyc++;
        end else begin
          awready = 1'b0;
          wready  = 1'b0;
        end

        if (awvalid && aw_got) dup_aw++;
        if (wvalid && w_got) dup_w++;
        if (aw_pend && (!awvalid || awaddr != pend_addr)) unstable++;
        if (w_pend && (!wvalid || wdata != pend_data)) unstable++;
        aw_pend = awvalid && !awready; pend_addr = awaddr;
        w_pend  = wvalid && !wready;   pend_data = wdata;

        if (awvalid && awready) begin aw_got = 1; got_addr = awaddr; end
        if (wvalid && wready) begin w_got = 1; got_data = wdata; end
        if (bvalid && bready) begin
          if (got_addr[1:0] != 2'b00 || int'(got_addr >> 2) >= N) begin
            bad_addr++;
          end else begin
            mem[got_addr >> 2] = got_data;
            wcnt[got_addr >> 2]++;
          end
          aw_got = 0; w_got = 0; cyc = 0; b_wait = 0;
        end

        if (w_tready && (awvalid || wvalid || bready)) tready_viol++;
        if (w_tvalid && w_tready) src_ptr++;
      end
    end
  end

  task automatic fill_src(input bit seq_words);
    for (int i = 0; i < N; i++) src_w[i] = seq_words ? 32'(i + 1) : $urandom;
    load_id++;
    @(negedge clk);
  endtask

  task automatic run_load(input string name, input bit seq_words, input bit check_lat,
                          input bit mid_pulse);
    int unsigned t0;
    int          k, nbad, exp_err;
    logic [31:0] sum_mem, sum_exp;
    fill_src(seq_words);
    exp_err = 0;
    for (int i = 0; i < N; i++) if (err_en && (4 * i == 16 || 4 * i == 32)) exp_err++;
    check_eq({name, ":busy_pre"}, 32'(load_busy), 0);
    load_start = 1'b1;
    t0 = cycle;
    @(negedge clk);
    load_start = 1'b0;
    check_eq({name, ":busy_rise"}, 32'(load_busy), 1);
    check_eq({name, ":err_clr"}, 32'(err_count), 0);
    k = 0;
    while (!load_done && k < 40000) begin
      load_start = mid_pulse && (k % 400 == 200);
      @(negedge clk);
      k++;
    end
    load_start = 1'b0;
    check_eq({name, ":done_seen"}, 32'(load_done), 1);
    if (check_lat) check_eq({name, ":latency"}, cycle - t0, 3 * N + 1);
    check_eq({name, ":busy_at_done"}, 32'(load_busy), 1);
    @(negedge clk);
    check_eq({name, ":busy_fall"}, 32'(load_busy), 0);
    check_eq({name, ":done_width"}, 32'(load_done), 0);
    repeat (5) @(negedge clk);
    check_eq({name, ":done_cnt"}, done_cnt, 1);
    check_eq({name, ":err_count"}, 32'(err_count), exp_err);
    check_eq({name, ":words_taken"}, src_ptr, N);
    check_eq({name, ":bad_addr"}, bad_addr, 0);
    check_eq({name, ":dup_aw_w"}, dup_aw + dup_w, 0);
    check_eq({name, ":stable"}, unstable, 0);
    check_eq({name, ":tready_fetch"}, tready_viol, 0);
    nbad = 0; sum_mem = '0; sum_exp = '0;
    for (int i = 0; i < N; i++) begin
      if (wcnt[i] != 1 || mem[i] != src_w[i]) nbad++;
      sum_mem += mem[i];
      sum_exp += src_w[i];
    end
    check_eq({name, ":mem"}, nbad, 0);
    check_eq({name, ":sum"}, sum_mem, seq_words ? 32'd307720 : sum_exp);
  endtask

  initial begin
    int k;
    rst_n = 1'b1; load_start = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst:w_tready", 32'(w_tready), 0);
    check_eq("rst:awvalid", 32'(awvalid), 0);
    check_eq("rst:wvalid", 32'(wvalid), 0);
    check_eq("rst:bready", 32'(bready), 0);
    check_eq("rst:busy", 32'(load_busy), 0);
    check_eq("rst:done", 32'(load_done), 0);
    check_eq("rst:awaddr", 32'(awaddr), 0);
    check_eq("rst:wdata", wdata, 0);
    check_eq("rst:err", 32'(err_count), 0);
    check_eq("const:awprot", 32'(awprot), 0);
    check_eq("const:wstrb", 32'(wstrb), 32'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    src_mode = 0; rsp_mode = 0; err_en = 0;
    run_load("zero_wait", 1, 1, 0);
    rsp_mode = 1;
    run_load("aw_first", 0, 0, 0);
    rsp_mode = 2;
    run_load("w_first", 0, 0, 0);
    src_mode = 1; rsp_mode = 0;
    run_load("toggle", 0, 0, 0);
    src_mode = 2; rsp_mode = 3; err_en = 1;
    run_load("slverr_mid", 0, 0, 1);
    src_mode = 0; rsp_mode = 0; err_en = 0;
    run_load("reload", 0, 1, 0);

    // Abandon a load while weight 100 is in its write phase.
    rsp_mode = 1;
    fill_src(0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    k = 0;
    while (!(awvalid && wvalid && src_ptr == 101) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_mid:reached_w100", 32'(awvalid && wvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid:awvalid", 32'(awvalid), 0);
    check_eq("rst_mid:wvalid", 32'(wvalid), 0);
    check_eq("rst_mid:busy", 32'(load_busy), 0);
    check_eq("rst_mid:awaddr", 32'(awaddr), 0);
    repeat (3) @(negedge clk);
    check_eq("rst_mid:no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_mode = 0;
    run_load("after_rst", 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
